// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and state encoding for the ALU command sequencer.
package alu_op_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    localparam logic [SEL_W-1:0] MUL_SEL = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB_HI = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// 8x8 register file: one synchronous write port, three asynchronous read ports.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [AW-1:0]     raddr3_i,
    output logic [DATA_W-1:0] rdata3_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven issuer for the external combinational ALU: reads operands from the
// register file, drives the ALU from registers, writes back and returns a response.
module alu_op_sequencer #(
    parameter int                 DATA_W  = alu_op_sequencer_pkg::DATA_W,
    parameter int                 SEL_W   = alu_op_sequencer_pkg::SEL_W,
    parameter int                 NREG    = alu_op_sequencer_pkg::NREG,
    parameter logic [SEL_W-1:0]   MUL_SEL = alu_op_sequencer_pkg::MUL_SEL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_load,
    input  logic [SEL_W-1:0]         cmd_sel,
    input  logic [$clog2(NREG)-1:0]  cmd_rd,
    input  logic [$clog2(NREG)-1:0]  cmd_rs1,
    input  logic [$clog2(NREG)-1:0]  cmd_rs2,
    input  logic                     cmd_imm_en,
    input  logic [DATA_W-1:0]        cmd_imm,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [SEL_W-1:0]         alu_sel,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [DATA_W-1:0]        alu_mul_high,
    input  logic [3:0]               alu_sreg,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [DATA_W-1:0]        rsp_mul_high,
    output logic [3:0]               rsp_sreg,
    output logic [3:0]               sreg,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    import alu_op_sequencer_pkg::*;

    localparam int AW = $clog2(NREG);

    state_e            state_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_mul_high_q;
    logic [3:0]        rsp_sreg_q;
    logic [3:0]        sreg_q;

    logic              we_d;
    logic [AW-1:0]     waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we_d),
        .waddr_i  (waddr_d),
        .wdata_i  (wdata_d),
        .raddr1_i (cmd_rs1),
        .rdata1_o (rs1_data),
        .raddr2_i (cmd_rs2),
        .rdata2_o (rs2_data),
        .raddr3_i (dbg_addr),
        .rdata3_o (dbg_data)
    );

    // Single write port shared by loads (IDLE), result (EXEC) and high byte (WB_HI).
    always_comb begin
        we_d    = 1'b0;
        waddr_d = rd_q;
        wdata_d = alu_result;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_load) begin
                    we_d    = 1'b1;
                    waddr_d = cmd_rd;
                    wdata_d = cmd_imm;
                end
            end
            ST_EXEC: begin
                we_d = 1'b1;
            end
            ST_WB_HI: begin
                we_d    = 1'b1;
                waddr_d = rd_q + AW'(1);
                wdata_d = rsp_mul_high_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rd_q           <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_sel_q      <= '0;
            rsp_data_q     <= '0;
            rsp_mul_high_q <= '0;
            rsp_sreg_q     <= '0;
            sreg_q         <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && !cmd_load) begin
                        alu_a_q   <= rs1_data;
                        alu_b_q   <= cmd_imm_en ? cmd_imm : rs2_data;
                        alu_sel_q <= cmd_sel;
                        rd_q      <= cmd_rd;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q     <= alu_result;
                    rsp_sreg_q     <= alu_sreg;
                    sreg_q         <= alu_sreg;
                    rsp_mul_high_q <= (alu_sel_q == MUL_SEL) ? alu_mul_high : '0;
                    state_q        <= (alu_sel_q == MUL_SEL) ? ST_WB_HI : ST_RESP;
                end
                ST_WB_HI: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_mul_high = rsp_mul_high_q;
    assign rsp_sreg     = rsp_sreg_q;
    assign sreg         = sreg_q;

endmodule
